// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 serial transmitter on the data-memory bus.
// Writes to TX_ADDR queue a byte in a 4-entry FIFO. An FSM shifts each byte out
// LSB first, framed by one start bit and one stop bit. STAT_ADDR reads back
// {count, ovf, full, busy}. Writing STAT_ADDR with bit 2 set clears ovf.
//
// Ports:
//   clk     in   1  clock, rising edge
//   rst     in   1  synchronous active-high reset
//   d_addr  in  16  bus address
//   w_data  in  16  write data (only [7:0] is used at TX_ADDR)
//   d_wr    in   1  write strobe
//   d_rd    in   1  read strobe
//   r_data  out 16  combinational read data
//   sel     out  1  combinational address claim (TX_ADDR or STAT_ADDR)
//   tx      out  1  registered serial output, idles high
//   busy    out  1  FSM not idle or FIFO non-empty
module mmio_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter logic [15:0] TX_ADDR      = 16'h00FF,
   parameter logic [15:0] STAT_ADDR    = 16'h00FE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] d_addr,
   input  logic [15:0] w_data,
   input  logic        d_wr,
   input  logic        d_rd,
   output logic [15:0] r_data,
   output logic        sel,
   output logic        tx,
   output logic        busy
);

   localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e          state_q;
   logic [CntW-1:0] baud_q;
   logic [2:0]      bit_q;
   logic [7:0]      shift_q;
   logic            tx_q;

   logic [7:0]      mem_q [4];
   logic [1:0]      wr_ptr_q;
   logic [1:0]      rd_ptr_q;
   logic [2:0]      count_q;
   logic            ovf_q;

   logic            hit_tx;
   logic            hit_stat;
   logic            full;
   logic            empty;
   logic            push;
   logic            pop;
   logic            baud_end;
   logic [7:0]      rd_byte;
   logic            unused_wdata;

   assign hit_tx   = (d_addr == TX_ADDR);
   assign hit_stat = (d_addr == STAT_ADDR);
   assign sel      = hit_tx | hit_stat;

   assign full     = (count_q == 3'(FIFO_DEPTH));
   assign empty    = (count_q == 3'd0);
   assign baud_end = (baud_q == CntW'(CLKS_PER_BIT - 1));
   assign rd_byte  = mem_q[rd_ptr_q];

   // The FSM takes the next byte either from idle or at the last stop cycle,
   // so back-to-back frames have no idle gap.
   assign pop  = !empty && ((state_q == StIdle) || ((state_q == StStop) && baud_end));
   // Fullness is judged before the edge: a simultaneous pop does not make room.
   assign push = d_wr && hit_tx && !full;

   assign tx   = tx_q;
   assign busy = (state_q != StIdle) || !empty;

   assign unused_wdata = ^w_data[15:8];

   // FIFO and overflow flag
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= 2'd0;
         rd_ptr_q <= 2'd0;
         count_q  <= 3'd0;
         ovf_q    <= 1'b0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= w_data[7:0];
            wr_ptr_q        <= wr_ptr_q + 2'd1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 2'd1;
         end
         if (push && !pop) begin
            count_q <= count_q + 3'd1;
         end else if (pop && !push) begin
            count_q <= count_q - 3'd1;
         end
         if (d_wr && hit_tx && full) begin
            ovf_q <= 1'b1;
         end else if (d_wr && hit_stat && w_data[2]) begin
            ovf_q <= 1'b0;
         end
      end
   end

   // Transmit FSM; tx is registered so the line never glitches.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         baud_q  <= '0;
         bit_q   <= 3'd0;
         shift_q <= 8'd0;
         tx_q    <= 1'b1;
      end else begin
         unique case (state_q)
            StIdle: begin
               tx_q <= 1'b1;
               if (pop) begin
                  shift_q <= rd_byte;
                  baud_q  <= '0;
                  tx_q    <= 1'b0;
                  state_q <= StStart;
               end
            end
            StStart: begin
               if (baud_end) begin
                  baud_q  <= '0;
                  bit_q   <= 3'd0;
                  tx_q    <= shift_q[0];
                  state_q <= StData;
               end else begin
                  baud_q <= baud_q + CntW'(1);
               end
            end
            StData: begin
               if (baud_end) begin
                  baud_q <= '0;
                  if (bit_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= StStop;
                  end else begin
                     // Next bit is shift_q[1]: it becomes bit 0 after this shift.
                     shift_q <= {1'b0, shift_q[7:1]};
                     tx_q    <= shift_q[1];
                     bit_q   <= bit_q + 3'd1;
                  end
               end else begin
                  baud_q <= baud_q + CntW'(1);
               end
            end
            StStop: begin
               if (baud_end) begin
                  baud_q <= '0;
                  if (pop) begin
                     shift_q <= rd_byte;
                     tx_q    <= 1'b0;
                     state_q <= StStart;
                  end else begin
                     tx_q    <= 1'b1;
                     state_q <= StIdle;
                  end
               end else begin
                  baud_q <= baud_q + CntW'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Read mux: only the status register returns data.
   always_comb begin
      r_data = 16'h0000;
      if (d_rd && hit_stat) begin
         r_data = {10'b0, count_q, ovf_q, full, busy};
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx with CLKS_PER_BIT=4. It uses a frame-time reference
// model, an 8N1 line decoder and directed tests with literal expectations.
module tb_mmio_uart_tx;

   localparam int CPB = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] d_addr = 16'h0000;
   logic [15:0] w_data = 16'h0000;
   logic        d_wr = 1'b0;
   logic        d_rd = 1'b0;
   logic [15:0] r_data;
   logic        sel;
   logic        tx;
   logic        busy;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   mmio_uart_tx #(
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (4),
      .TX_ADDR     (16'h00FF),
      .STAT_ADDR   (16'h00FE)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .d_addr(d_addr),
      .w_data(w_data),
      .d_wr  (d_wr),
      .d_rd  (d_rd),
      .r_data(r_data),
      .sel   (sel),
      .tx    (tx),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: queued bytes plus a frame-time position (-1 = idle line).
   logic [7:0] m_q[$];
   int         m_ft = -1;
   logic [7:0] m_fb = 8'h00;
   bit         m_ovf = 1'b0;
   int         m_n;
   bit         m_push;

   always @(posedge clk) begin
      if (rst) begin
         m_q.delete();
         m_ft  = -1;
         m_ovf = 1'b0;
      end else begin
         m_n    = m_q.size();
         m_push = d_wr && (d_addr == 16'h00FF) && (m_n < 4);
         if (d_wr && (d_addr == 16'h00FF) && (m_n >= 4)) m_ovf = 1'b1;
         if (d_wr && (d_addr == 16'h00FE) && w_data[2]) m_ovf = 1'b0;
         if (m_ft < 0 || m_ft == 10 * CPB - 1) begin
            if (m_n > 0) begin
               m_fb = m_q.pop_front();
               m_ft = 0;
            end else begin
               m_ft = -1;
            end
         end else begin
            m_ft++;
         end
         if (m_push) m_q.push_back(w_data[7:0]);
      end
   end

   function automatic logic exp_tx();
      int b;
      if (m_ft < 0) return 1'b1;
      b = m_ft / CPB;
      if (b == 0) return 1'b0;
      if (b == 9) return 1'b1;
      return m_fb[b-1];
   endfunction

   function automatic logic exp_busy();
      return (m_ft >= 0) || (m_q.size() != 0);
   endfunction

   function automatic logic [15:0] exp_stat();
      return {10'b0, 3'(m_q.size()), m_ovf, (m_q.size() == 4), exp_busy()};
   endfunction

   // Per-cycle comparison against the model, just after each active edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (chk_en) begin
            chk("tx", 16'(tx), 16'(exp_tx()));
            chk("busy", 16'(busy), 16'(exp_busy()));
            chk("sel", 16'(sel), 16'((d_addr == 16'h00FF) || (d_addr == 16'h00FE)));
            if (d_rd) begin
               chk("r_data", r_data, (d_addr == 16'h00FE) ? exp_stat() : 16'h0000);
            end
         end
      end
   end

   // Line decoder: samples mid-bit, aborts on reset.
   logic [7:0] decoded[$];
   int         mon_s = -1;
   logic [7:0] mon_b = 8'h00;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            mon_s = -1;
         end else if (mon_s < 0) begin
            if (tx === 1'b0) mon_s = 0;
         end else begin
            mon_s++;
            if ((mon_s % CPB == CPB / 2) && (mon_s / CPB >= 1) && (mon_s / CPB <= 8)) begin
               mon_b[mon_s/CPB-1] = tx;
            end
            if (mon_s == 9 * CPB + CPB / 2) begin
               chk("stop_bit", 16'(tx), 16'h0001);
               decoded.push_back(mon_b);
               mon_s = -1;
            end
         end
      end
   end

   // Data-memory stand-in, write-gated by sel.
   logic [15:0] dmem [256];
   always @(posedge clk) begin
      if (d_wr && !sel) dmem[d_addr[7:0]] <= w_data;
   end

   // Drive a write; returns 1 time unit after the edge that samples it.
   task automatic wr(input logic [15:0] a, input logic [15:0] v);
      @(negedge clk);
      d_addr = a;
      w_data = v;
      d_wr   = 1'b1;
      d_rd   = 1'b0;
      @(posedge clk);
      #1;
      d_wr = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a, output logic [15:0] v);
      @(negedge clk);
      d_addr = a;
      d_wr   = 1'b0;
      d_rd   = 1'b1;
      #1;
      v = r_data;
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      while (busy !== 1'b0 && n < max) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("idle_timeout", 16'(busy), 16'h0000);
   endtask

   task automatic chk_decoded(input string name, input logic [7:0] exp[$]);
      chk({name, "_count"}, 16'(decoded.size()), 16'(exp.size()));
      for (int i = 0; i < exp.size() && i < decoded.size(); i++) begin
         chk(name, 16'(decoded[i]), 16'(exp[i]));
      end
      decoded.delete();
   endtask

   logic [15:0] v;
   logic [9:0]  frame_0d;
   int          n;
   int          hi;

   initial begin
      for (int i = 0; i < 256; i++) dmem[i] = 16'h0000;
      dmem[8'hFF] = 16'hDEAD;

      // Reset
      repeat (3) @(negedge clk);
      rst    = 1'b0;
      chk_en = 1'b1;
      #1;
      chk("rst_tx", 16'(tx), 16'h0001);
      chk("rst_busy", 16'(busy), 16'h0000);
      rd(16'h00FE, v);
      chk("rst_stat", v, 16'h0000);

      // Single 0x0D frame: {stop, data[7:0], start}
      frame_0d = 10'b1_00001101_0;
      wr(16'h00FF, 16'h000D);
      chk("t1_tx_c0", 16'(tx), 16'h0001);
      chk("t1_busy_c0", 16'(busy), 16'h0001);
      for (int c = 1; c <= 41; c++) begin
         @(posedge clk);
         #1;
         if (c <= 40) chk("t1_frame", 16'(tx), 16'(frame_0d[(c-1)/CPB]));
         if (c == 40) chk("t1_busy_c40", 16'(busy), 16'h0001);
         if (c == 41) chk("t1_busy_c41", 16'(busy), 16'h0000);
      end
      chk_decoded("t1_byte", '{8'h0D});

      // Back-to-back 0x55, 0xAA
      wr(16'h00FF, 16'h0055);
      wr(16'h00FF, 16'h00AA);
      chk("t2_start", 16'(tx), 16'h0000);
      n  = 0;
      hi = 0;
      while (busy === 1'b1 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
         if (busy === 1'b1 && tx === 1'b1) hi++;
      end
      chk("t2_len", 16'(n), 16'd80);
      chk("t2_high_cycles", 16'(hi), 16'd40);
      chk_decoded("t2_byte", '{8'h55, 8'hAA});

      // Overflow: six writes, the sixth is dropped
      for (int i = 1; i <= 6; i++) wr(16'h00FF, 16'(i));
      rd(16'h00FE, v);
      chk("t3_stat_full", v, 16'h0027);
      wait_idle(400);
      chk_decoded("t3_byte", '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05});
      rd(16'h00FE, v);
      chk("t3_stat_ovf", v, 16'h0004);
      wr(16'h00FE, 16'h0004);
      rd(16'h00FE, v);
      chk("t3_stat_clr", v, 16'h0000);

      // Reset mid-DATA with two bytes queued and a write in the reset cycle
      wr(16'h00FF, 16'h000D);
      wr(16'h00FF, 16'h000E);
      wr(16'h00FF, 16'h000F);
      repeat (8) @(posedge clk);
      @(negedge clk);
      rst    = 1'b1;
      d_addr = 16'h00FF;
      w_data = 16'h0077;
      d_wr   = 1'b1;
      @(posedge clk);
      #1;
      chk("t4_tx", 16'(tx), 16'h0001);
      chk("t4_busy", 16'(busy), 16'h0000);
      @(negedge clk);
      rst  = 1'b0;
      d_wr = 1'b0;
      rd(16'h00FE, v);
      chk("t4_stat", v, 16'h0000);
      hi = 0;
      for (int c = 0; c < 100; c++) begin
         @(posedge clk);
         #1;
         if (tx === 1'b1) hi++;
      end
      chk("t4_line_high", 16'(hi), 16'd100);
      chk_decoded("t4_byte", '{});

      // Unclaimed addresses
      wr(16'h00FD, 16'h1234);
      chk("t5_sel_fd", 16'(sel), 16'h0000);
      wr(16'h0000, 16'h5678);
      chk("t5_sel_00", 16'(sel), 16'h0000);
      repeat (10) @(posedge clk);
      #1;
      chk("t5_busy", 16'(busy), 16'h0000);
      rd(16'h00FE, v);
      chk("t5_stat", v, 16'h0000);
      rd(16'h00FF, v);
      chk("t5_rd_tx", v, 16'h0000);
      chk("t5_sel_ff", 16'(sel), 16'h0001);
      chk("t5_dmem_fd", dmem[8'hFD], 16'h1234);
      chk("t5_dmem_00", dmem[8'h00], 16'h5678);
      chk_decoded("t5_byte", '{});

      // Program-style store of 0x0D to the data register
      wr(16'h00FF, 16'h000D);
      wait_idle(100);
      chk_decoded("t6_byte", '{8'h0D});
      chk("t6_dmem_ff", dmem[8'hFF], 16'hDEAD);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
